run_len_detect: RTL and testbench

Parametrised serial run-length detector: counts consecutive bits of a selectable polarity on a 1-bit serial stream, gated by an enable. It adds saturate/wrap modes, a threshold-hit pulse, end-of-run length capture and a longest-run tracker. It sits after the serial receiver as a generalised run counter for framing, idle detection and bit-stuffing checks.

---
 rtl/run_len_detect.sv | 92 +++++++++
 tb/tb_run_len_detect.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/run_len_detect.sv
// Serial run-length detector: counts consecutive bits of a chosen polarity, gated by i_en.
// Latency: 1 clock from sample to every output (o_sat follows the registered count/mode).
// Backpressure: none; i_en low freezes all state and suppresses the pulses.
module run_len_detect #(
  parameter int WIDTH  = 3,
  parameter int ULIMIT = 5,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             i_sclr_n,
  input  logic             i_en,
  input  logic             i_dat,
  input  logic             i_pol,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_hit,
  output logic             o_sat,
  output logic             o_wrap,
  output logic             o_done,
  output logic [WIDTH-1:0] o_run_len,
  output logic [WIDTH-1:0] o_max
);

  localparam logic [WIDTH-1:0] ULIM = WIDTH'(ULIMIT);
  localparam logic [WIDTH-1:0] THR  = WIDTH'(THRESH);
  localparam bit               HIT_ON = (THRESH != 0);

  logic             match;
  logic             at_lim;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             hit_nxt;
  logic             run_end;
  logic             mode_q;

  // Next count: increment on match, saturate or wrap at the terminal count, clear on mismatch
  always_comb begin
    match    = (i_dat == i_pol);
    at_lim   = (o_cnt == ULIM);
    cnt_nxt  = '0;
    wrap_nxt = 1'b0;
    if (match) begin
      if (!at_lim) begin
        cnt_nxt = o_cnt + WIDTH'(1);
      end else if (i_mode) begin
        cnt_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        cnt_nxt = o_cnt;
      end
    end
    // hit only on the transition into THRESH, so a count saturated at THRESH fires once
    hit_nxt = HIT_ON && (cnt_nxt == THR) && (o_cnt != THR);
    // a run ends only when a mismatch breaks a non-empty count
    run_end = !match && (o_cnt != '0);
  end

  // Registered state: count, pulses, captured run length, longest run and sampled mode
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      o_cnt     <= '0;
      o_hit     <= 1'b0;
      o_wrap    <= 1'b0;
      o_done    <= 1'b0;
      o_run_len <= '0;
      o_max     <= '0;
      mode_q    <= 1'b0;
    end else if (!i_en) begin
      o_hit  <= 1'b0;
      o_wrap <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_cnt  <= cnt_nxt;
      o_hit  <= hit_nxt;
      o_wrap <= wrap_nxt;
      o_done <= run_end;
      mode_q <= i_mode;
      if (run_end) begin
        o_run_len <= o_cnt;
        if (o_cnt > o_max) begin
          o_max <= o_cnt;
        end
      end
    end
  end

  // Saturation level comes from the registered count and the mode in force when it was taken
  always_comb begin
    o_sat = (o_cnt == ULIM) && !mode_q;
  end

endmodule

// File: tb/tb_run_len_detect.sv
// Bench for run_len_detect: directed scenarios with literal expectations plus a random
// stream, all checked every cycle against an integer-level model of the run rules.
module tb_run_len_detect;
  localparam int WIDTH  = 3;
  localparam int ULIMIT = 5;
  localparam int THRESH = 3;

  logic             clk = 1'b0;
  logic             sclr_n = 1'b0;
  logic             en = 1'b0;
  logic             dat = 1'b0;
  logic             pol = 1'b1;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] cnt;
  logic             hit, sat, wrap, done;
  logic [WIDTH-1:0] run_len, max_len;

  int n_chk = 0;
  int n_fail = 0;

  // model state, plain integers
  int m_cnt = 0, m_len = 0, m_max = 0;
  int m_hit = 0, m_wrap = 0, m_done = 0, m_sat = 0, m_mode = 0;

  always #5 clk = ~clk;

  run_len_detect #(.WIDTH(WIDTH), .ULIMIT(ULIMIT), .THRESH(THRESH)) dut (
    .clk(clk), .i_sclr_n(sclr_n), .i_en(en), .i_dat(dat), .i_pol(pol), .i_mode(mode),
    .o_cnt(cnt), .o_hit(hit), .o_sat(sat), .o_wrap(wrap), .o_done(done),
    .o_run_len(run_len), .o_max(max_len)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model update at each edge, then compare every output 1 time unit later
  always @(posedge clk) begin
    int old;
    if (!sclr_n) begin
      m_cnt = 0; m_len = 0; m_max = 0; m_mode = 0;
      m_hit = 0; m_wrap = 0; m_done = 0;
    end else if (!en) begin
      m_hit = 0; m_wrap = 0; m_done = 0;
    end else begin
      old    = m_cnt;
      m_mode = mode;
      m_wrap = 0;
      m_done = 0;
      if (dat == pol) begin
        if (old < ULIMIT) m_cnt = old + 1;
        else if (mode) begin m_cnt = 0; m_wrap = 1; end
      end else begin
        m_cnt = 0;
        if (old != 0) begin
          m_done = 1;
          m_len  = old;
          if (old > m_max) m_max = old;
        end
      end
      m_hit = (THRESH != 0 && m_cnt == THRESH && old != THRESH) ? 1 : 0;
    end
    m_sat = (m_cnt == ULIMIT && m_mode == 0) ? 1 : 0;
    #1;
    chk("m_cnt", 8'(cnt), 8'(m_cnt));
    chk("m_hit", 8'(hit), 8'(m_hit));
    chk("m_sat", 8'(sat), 8'(m_sat));
    chk("m_wrap", 8'(wrap), 8'(m_wrap));
    chk("m_done", 8'(done), 8'(m_done));
    chk("m_run_len", 8'(run_len), 8'(m_len));
    chk("m_max", 8'(max_len), 8'(m_max));
  end

  // drive inputs on the falling edge, return 2 time units after the next rising edge
  task automatic step(input logic d, input logic e, input logic r);
    @(negedge clk);
    dat = d; en = e; sclr_n = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int sat_cnt[8]  = '{1, 2, 3, 4, 5, 5, 5, 0};
    int sat_lvl[8]  = '{0, 0, 0, 0, 1, 1, 1, 0};
    int wrp_cnt[8]  = '{1, 2, 3, 4, 5, 0, 1, 0};
    int wrp_pls[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    int wrp_hit[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic r, e, d;

    // reset
    step(1'b1, 1'b1, 1'b0);
    chk("rst_cnt", 8'(cnt), 8'd0);
    chk("rst_len", 8'(run_len), 8'd0);
    chk("rst_max", 8'(max_len), 8'd0);
    chk("rst_pulses", {4'd0, hit, sat, wrap, done}, 8'd0);
    step(1'b1, 1'b0, 1'b1);
    chk("idle_cnt", 8'(cnt), 8'd0);

    // basic run of three ones
    pol = 1'b1; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk("basic_cnt", 8'(cnt), 8'(i + 1));
      chk("basic_hit", 8'(hit), (i == 2) ? 8'd1 : 8'd0);
    end
    step(1'b0, 1'b1, 1'b1);
    chk("basic_end_cnt", 8'(cnt), 8'd0);
    chk("basic_done", 8'(done), 8'd1);
    chk("basic_len", 8'(run_len), 8'd3);
    chk("basic_max", 8'(max_len), 8'd3);

    // saturate
    for (int i = 0; i < 8; i++) begin
      step((i < 7) ? 1'b1 : 1'b0, 1'b1, 1'b1);
      chk("sat_cnt", 8'(cnt), 8'(sat_cnt[i]));
      chk("sat_lvl", 8'(sat), 8'(sat_lvl[i]));
    end
    chk("sat_len", 8'(run_len), 8'd5);
    chk("sat_max", 8'(max_len), 8'd5);

    // wrap
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step((i < 7) ? 1'b1 : 1'b0, 1'b1, 1'b1);
      chk("wrap_cnt", 8'(cnt), 8'(wrp_cnt[i]));
      chk("wrap_pulse", 8'(wrap), 8'(wrp_pls[i]));
      chk("wrap_hit", 8'(hit), 8'(wrp_hit[i]));
      chk("wrap_sat", 8'(sat), 8'd0);
    end
    chk("wrap_done", 8'(done), 8'd1);
    chk("wrap_len", 8'(run_len), 8'd1);
    chk("wrap_max", 8'(max_len), 8'd5);

    // enable gating
    mode = 1'b0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("gate_cnt", 8'(cnt), 8'd2);
      chk("gate_done", 8'(done), 8'd0);
    end
    step(1'b1, 1'b1, 1'b1);
    chk("gate_resume_cnt", 8'(cnt), 8'd3);
    chk("gate_resume_hit", 8'(hit), 8'd1);
    step(1'b0, 1'b1, 1'b1);
    chk("gate_end_len", 8'(run_len), 8'd3);

    // zero polarity, reset mid-run
    pol = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    chk("zpol_cnt", 8'(cnt), 8'd4);
    step(1'b1, 1'b1, 1'b0);
    chk("zrst_cnt", 8'(cnt), 8'd0);
    chk("zrst_max", 8'(max_len), 8'd0);
    chk("zrst_done", 8'(done), 8'd0);

    // random stream, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(31) == 0) pol = ~pol;
      if ($urandom_range(15) == 0) mode = ~mode;
      r = ($urandom_range(199) != 0);
      e = ($urandom_range(7) != 0);
      d = ($urandom_range(3) != 0) ? pol : ~pol;
      step(d, e, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
